// File: rtl/peecc_run_controller_if.sv
// rtl/peecc_run_controller_if.sv - control/result bundle between run controller and PEECC data path
interface peecc_run_controller_if #(
    parameter int ERR_W = 11
);
    logic             start;
    logic             abort;
    logic             isequal;
    logic [4:0]       max_reg;
    logic [21:0]      sum_transitions;
    logic             en_gen_data;
    logic             en_enc;
    logic             en_bus;
    logic             en_trans_count;
    logic             en_dec;
    logic             en_k_comp;
    logic             done;
    logic             busy;
    logic             finished;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [4:0]       res_max_reg;
    logic [21:0]      res_sum;

    modport master (
        input  start, abort, isequal, max_reg, sum_transitions,
        output en_gen_data, en_enc, en_bus, en_trans_count, en_dec, en_k_comp,
        output done, busy, finished, pass, err_count, res_max_reg, res_sum
    );

    modport slave (
        output start, abort, isequal, max_reg, sum_transitions,
        input  en_gen_data, en_enc, en_bus, en_trans_count, en_dec, en_k_comp,
        input  done, busy, finished, pass, err_count, res_max_reg, res_sum
    );
endinterface

// File: rtl/peecc_run_controller.sv
// rtl/peecc_run_controller.sv - sequences one PEECC measurement run and latches its results
module peecc_run_controller #(
    parameter int NUM_WORDS = 1024,
    parameter int CNT_W     = 11,
    parameter int ERR_W     = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    peecc_run_controller_if.master  pi
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DONE_P  = 3'd2,
        CAPTURE = 3'd3,
        REPORT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_WORDS + 4);
    localparam logic [CNT_W-1:0] WORDS  = CNT_W'(NUM_WORDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] c_q;
    logic             start_q;
    logic             cmp_valid_q;
    logic [ERR_W-1:0] err_q;
    logic [4:0]       res_max_q;
    logic [21:0]      res_sum_q;
    logic [4:0]       en;
    logic             start_edge;
    logic             enter_run;

    assign start_edge = pi.start & ~start_q;
    assign enter_run  = ((state_q == IDLE) || (state_q == REPORT)) && start_edge;

    // c - s wraps to a large value when c < s, so one unsigned compare covers both bounds
    always_comb begin
        en = '0;
        for (int s = 0; s < 5; s++) begin
            en[s] = (state_q == RUN) && ((c_q - CNT_W'(s)) < WORDS);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = RUN;
            RUN:     if (pi.abort) state_d = IDLE;
                     else if (c_q == LAST_C) state_d = DONE_P;
            DONE_P:  state_d = pi.abort ? IDLE : CAPTURE;
            CAPTURE: state_d = pi.abort ? IDLE : REPORT;
            REPORT:  if (start_edge) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_q         <= '0;
            start_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            err_q       <= '0;
            res_max_q   <= '0;
            res_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= pi.start;
            cmp_valid_q <= en[4];
            c_q         <= (state_q == RUN && state_d == RUN) ? c_q + 1'b1 : '0;
            if (enter_run) begin
                err_q <= '0;
            end else if (state_q == RUN && cmp_valid_q && !pi.isequal
                         && err_q != {ERR_W{1'b1}}) begin
                err_q <= err_q + 1'b1;
            end
            if (state_q == CAPTURE && !pi.abort) begin
                res_max_q <= pi.max_reg;
                res_sum_q <= pi.sum_transitions;
            end
        end
    end

    assign pi.en_gen_data    = en[0];
    assign pi.en_enc         = en[1];
    assign pi.en_bus         = en[2];
    assign pi.en_trans_count = en[2];
    assign pi.en_dec         = en[3];
    assign pi.en_k_comp      = en[4];
    assign pi.done           = (state_q == DONE_P);
    assign pi.busy           = (state_q == RUN) || (state_q == DONE_P) || (state_q == CAPTURE);
    assign pi.finished       = (state_q == REPORT);
    assign pi.pass           = (state_q == REPORT) && (err_q == '0);
    assign pi.err_count      = err_q;
    assign pi.res_max_reg    = res_max_q;
    assign pi.res_sum        = res_sum_q;
endmodule

// File: tb/tb_peecc_run_controller.sv
// tb/tb_peecc_run_controller.sv - directed self-checking bench for peecc_run_controller
module tb_peecc_run_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    peecc_run_controller_if #(.ERR_W(11)) a_if ();
    peecc_run_controller_if #(.ERR_W(3))  s_if ();
    peecc_run_controller_if #(.ERR_W(11)) o_if ();

    peecc_run_controller #(.NUM_WORDS(8),  .CNT_W(11), .ERR_W(11)) dut_a (.clk(clk), .rst_n(rst_n), .pi(a_if.master));
    peecc_run_controller #(.NUM_WORDS(20), .CNT_W(11), .ERR_W(3))  dut_s (.clk(clk), .rst_n(rst_n), .pi(s_if.master));
    peecc_run_controller #(.NUM_WORDS(1),  .CNT_W(11), .ERR_W(11)) dut_o (.clk(clk), .rst_n(rst_n), .pi(o_if.master));

    // {gen, enc, bus, trans, dec, k_comp, done, busy, finished, pass}
    logic [9:0] a_vec, s_vec, o_vec;
    assign a_vec = {a_if.en_gen_data, a_if.en_enc, a_if.en_bus, a_if.en_trans_count, a_if.en_dec,
                    a_if.en_k_comp, a_if.done, a_if.busy, a_if.finished, a_if.pass};
    assign s_vec = {s_if.en_gen_data, s_if.en_enc, s_if.en_bus, s_if.en_trans_count, s_if.en_dec,
                    s_if.en_k_comp, s_if.done, s_if.busy, s_if.finished, s_if.pass};
    assign o_vec = {o_if.en_gen_data, o_if.en_enc, o_if.en_bus, o_if.en_trans_count, o_if.en_dec,
                    o_if.en_k_comp, o_if.done, o_if.busy, o_if.finished, o_if.pass};

    // k = cycles since the start edge was taken (k = 0 is the first RUN cycle)
    function automatic logic [9:0] exp_vec(input int k, input int n, input bit pass_ok);
        logic [9:0] v;
        v    = '0;
        v[9] = (k >= 0) && (k <= n - 1);
        v[8] = (k >= 1) && (k <= n);
        v[7] = (k >= 2) && (k <= n + 1);
        v[6] = v[7];
        v[5] = (k >= 3) && (k <= n + 2);
        v[4] = (k >= 4) && (k <= n + 3);
        v[3] = (k == n + 5);
        v[2] = (k <= n + 6);
        v[1] = (k >= n + 7);
        v[0] = v[1] && pass_ok;
        return v;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({a_vec, s_vec, o_vec} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", {a_vec, s_vec, o_vec});
        end
        checks++;
        if ({a_if.err_count, a_if.res_max_reg, a_if.res_sum} !== '0) begin
            errors++;
            $display("FAIL reset_results got %h/%h/%h expected 0", a_if.err_count, a_if.res_max_reg, a_if.res_sum);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_run();
        @(negedge clk);
        a_if.start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== exp_vec(k, 8, 1'b1)) begin
                errors++;
                $display("FAIL basic_trace k=%0d got %b expected %b", k, a_vec, exp_vec(k, 8, 1'b1));
            end
            if (k == 1) a_if.start = 1'b0;
        end
        checks++;
        if (a_if.err_count !== 11'd0) begin
            errors++;
            $display("FAIL basic_err got %0d expected 0", a_if.err_count);
        end
    endtask

    task automatic test_mismatch();
        @(negedge clk);
        a_if.start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== exp_vec(k, 8, 1'b0)) begin
                errors++;
                $display("FAIL mismatch_trace k=%0d got %b expected %b", k, a_vec, exp_vec(k, 8, 1'b0));
            end
            if (k == 8) begin
                checks++;
                if (a_if.err_count !== 11'd1) begin
                    errors++;
                    $display("FAIL mismatch_mid got %0d expected 1", a_if.err_count);
                end
            end
            if (k == 1) a_if.start = 1'b0;
            a_if.isequal = !(k inside {2, 4, 7, 9, 13, 14});
        end
        checks++;
        if (a_if.err_count !== 11'd2) begin
            errors++;
            $display("FAIL mismatch_err got %0d expected 2", a_if.err_count);
        end
    endtask

    task automatic test_capture();
        a_if.max_reg = 5'd3;
        a_if.sum_transitions = 22'h012345;
        @(negedge clk);
        a_if.start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== exp_vec(k, 8, 1'b1)) begin
                errors++;
                $display("FAIL capture_trace k=%0d got %b expected %b", k, a_vec, exp_vec(k, 8, 1'b1));
            end
            if (k == 0) begin
                checks++;
                if (a_if.err_count !== 11'd0) begin
                    errors++;
                    $display("FAIL err_clear_on_start got %0d expected 0", a_if.err_count);
                end
            end
            if (k == 14 || k == 15 || k == 19) begin
                checks++;
                if ({a_if.res_max_reg, a_if.res_sum} !== ((k == 14) ? 27'd0 : {5'd18, 22'h3FF00})) begin
                    errors++;
                    $display("FAIL capture_res k=%0d got %0d/%h", k, a_if.res_max_reg, a_if.res_sum);
                end
            end
            if (k == 1) a_if.start = 1'b0;
            if (k == 14) begin
                a_if.max_reg = 5'd18;
                a_if.sum_transitions = 22'h3FF00;
            end
            if (k == 15) begin
                a_if.max_reg = 5'd3;
                a_if.sum_transitions = 22'h012345;
            end
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        a_if.start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== ((k <= 4) ? exp_vec(k, 8, 1'b1) : 10'd0)) begin
                errors++;
                $display("FAIL abort_trace k=%0d got %b expected %b", k, a_vec,
                         (k <= 4) ? exp_vec(k, 8, 1'b1) : 10'd0);
            end
            if (k == 1) a_if.start = 1'b0;
            if (k == 4) begin
                a_if.abort = 1'b1;
                a_if.start = 1'b1;
            end
            if (k == 5) a_if.abort = 1'b0;
            if (k == 6) a_if.start = 1'b0;
        end
        checks++;
        if ({a_if.res_max_reg, a_if.res_sum} !== {5'd18, 22'h3FF00}) begin
            errors++;
            $display("FAIL abort_res_hold got %0d/%h expected 18/3ff00", a_if.res_max_reg, a_if.res_sum);
        end
    endtask

    task automatic test_start_while_busy();
        @(negedge clk);
        a_if.start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== exp_vec(k, 8, 1'b1)) begin
                errors++;
                $display("FAIL busy_start_trace k=%0d got %b expected %b", k, a_vec, exp_vec(k, 8, 1'b1));
            end
            if (k inside {1, 5, 12, 16}) a_if.start = 1'b0;
            if (k inside {3, 9, 13})     a_if.start = 1'b1;
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a_if.start = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) a_if.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_vec !== 10'd0) begin
            errors++;
            $display("FAIL async_reset_enables got %b expected 0", a_vec);
        end
        @(negedge clk);
        checks++;
        if ({a_vec, a_if.err_count, a_if.res_max_reg, a_if.res_sum} !== '0) begin
            errors++;
            $display("FAIL reset_hold got %b/%0d/%0d/%h expected 0", a_vec, a_if.err_count,
                     a_if.res_max_reg, a_if.res_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_if.start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== exp_vec(k, 8, 1'b1)) begin
                errors++;
                $display("FAIL post_reset_trace k=%0d got %b expected %b", k, a_vec, exp_vec(k, 8, 1'b1));
            end
            if (k == 1) a_if.start = 1'b0;
        end
    endtask

    task automatic test_saturation();
        s_if.isequal = 1'b0;
        @(negedge clk);
        s_if.start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (s_vec !== exp_vec(k, 20, 1'b0)) begin
                errors++;
                $display("FAIL sat_trace k=%0d got %b expected %b", k, s_vec, exp_vec(k, 20, 1'b0));
            end
            if (k == 11 || k == 12 || k == 13) begin
                checks++;
                if (s_if.err_count !== ((k == 11) ? 3'd6 : 3'd7)) begin
                    errors++;
                    $display("FAIL sat_count k=%0d got %0d expected %0d", k, s_if.err_count, (k == 11) ? 6 : 7);
                end
            end
            if (k == 1) s_if.start = 1'b0;
        end
        checks++;
        if (s_if.err_count !== 3'd7) begin
            errors++;
            $display("FAIL sat_final got %0d expected 7", s_if.err_count);
        end
    endtask

    task automatic test_single_word();
        @(negedge clk);
        o_if.start = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checks++;
            if (o_vec !== exp_vec(k, 1, 1'b0)) begin
                errors++;
                $display("FAIL n1_trace k=%0d got %b expected %b", k, o_vec, exp_vec(k, 1, 1'b0));
            end
            if (k == 1) o_if.start = 1'b0;
            o_if.isequal = !(k inside {4, 5, 6});
        end
        checks++;
        if (o_if.err_count !== 11'd1) begin
            errors++;
            $display("FAIL n1_err got %0d expected 1", o_if.err_count);
        end
    endtask

    initial begin
        a_if.start = 1'b0; a_if.abort = 1'b0; a_if.isequal = 1'b1;
        a_if.max_reg = '0; a_if.sum_transitions = '0;
        s_if.start = 1'b0; s_if.abort = 1'b0; s_if.isequal = 1'b1;
        s_if.max_reg = '0; s_if.sum_transitions = '0;
        o_if.start = 1'b0; o_if.abort = 1'b0; o_if.isequal = 1'b1;
        o_if.max_reg = '0; o_if.sum_transitions = '0;
        test_reset();
        test_basic_run();
        test_mismatch();
        test_capture();
        test_abort();
        test_start_while_busy();
        test_reset_mid_run();
        test_saturation();
        test_single_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
